apu_noise: RTL and testbench
============================

APU_NOISE -- requirements
Module: apu_noise

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 15'h0001, which is the LFSR value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port apu_cycle, input, 1 bit: one-clk strobe that advances the noise timer.
REQ-005 SHALL have port qtrframe, input, 1 bit: one-clk strobe from the frame counter that clocks the envelope.
REQ-006 SHALL have port halfframe, input, 1 bit: one-clk strobe from the frame counter that clocks the length counter.
REQ-007 SHALL have port en, input, 1 bit: channel enable ($4015 bit 3).
REQ-008 SHALL have port reg_ctrl, input, 8 bits: $400C value; [5] is halt/loop, [4] is constant volume, [3:0] is volume/envelope period V.
REQ-009 SHALL have port reg_timelow, input, 8 bits: $400E value; [7] is mode, [3:0] is period index.
REQ-010 SHALL have port reg_timehigh, input, 8 bits: $400F value; [7:3] is length index.
REQ-011 SHALL have port reg_len_update, input, 1 bit: one-clk strobe, asserted the clk after a $400F write.
REQ-012 SHALL have port active, output, 1 bit: high when the length counter is non-zero.
REQ-013 SHALL have port sample, output, 4 bits: channel output to the mixer.

Function
REQ-014 SHALL map period index 0..15 to period P in APU cycles: 2,4,8,16,32,48,64,80,101,127,190,254,381,508,1017,2034.
REQ-015 SHALL update the 11-bit timer only on apu_cycle: if timer==0, reload it with P-1 and step the LFSR; otherwise decrement it.
REQ-016 SHALL give one LFSR step exactly every P apu_cycle strobes, with P sampled at reload time.
REQ-017 SHALL step the 15-bit LFSR as follows: fb = lfsr[0] XOR (mode ? lfsr[6] : lfsr[1]); lfsr <= {fb, lfsr[14:1]}.
REQ-018 SHALL never let the LFSR reach 0; the seed is non-zero and the polynomial preserves this.
REQ-019 SHALL map length index 0..31 as follows: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
REQ-020 SHALL load the length counter from the table on reg_len_update when en=1; when en=0 the strobe is ignored for length.
REQ-021 SHALL decrement the length counter on halfframe when halt=0 and length!=0; it saturates at 0.
REQ-022 SHALL give reg_len_update priority over halfframe when both occur in the same clk (load, no decrement).
REQ-023 SHALL clear the length counter to 0 on the first clk with en=0 and hold it at 0 while en=0.
REQ-024 SHALL set the envelope start flag on reg_len_update, regardless of en.
REQ-025 SHALL clock the envelope on qtrframe only: if start, clear start, set decay=15 and divider=V; else if divider==0, set divider=V and then decrement decay if decay!=0, else set decay=15 if loop=1; else decrement divider.
REQ-026 SHALL, when reg_len_update and qtrframe coincide, set start first, so the envelope restart occurs on that same qtrframe.
REQ-027 SHALL compute the volume as V when constant=1, otherwise decay.
REQ-028 SHALL register sample: sample <= (length==0 || lfsr[0]==1) ? 0 : volume, giving a latency of 1 clk after the state change.
REQ-029 SHALL drive active combinationally as (length!=0).
REQ-030 SHALL read register inputs live each clk, with no internal shadow copies.

Reset
REQ-031 SHALL, when rst=0 at a clk edge, set lfsr=LFSR_SEED, timer=0, length=0, divider=0, decay=0, start=0, and sample=0; active is therefore 0.
REQ-032 SHALL let reset override all strobes in the same clk, including mid-timer-count and mid-envelope.
REQ-033 SHALL resume operation on the first edge with rst=1, with the first LFSR step on the first apu_cycle.

Verification
REQ-034 SHALL pass this case: reset, en=1, reg_timelow=8'h00, pulse apu_cycle every other clk -> lfsr steps every 2 apu_cycles; sequence from seed 1 is 0x4000, 0x2000, ... (mode 0).
REQ-035 SHALL pass this case: mode=1 from seed 1, 93 steps -> lfsr returns to 1 (short sequence).
REQ-036 SHALL pass this case: en=1, reg_timehigh=8'h08 (index 1), reg_len_update -> length=254, active=1; 254 halfframes with halt=0 -> active=0 and sample=0.
REQ-037 SHALL pass this case: reg_ctrl=8'h1A (constant, V=10), length>0 -> sample is 10 whenever lfsr[0]==0 and 0 when lfsr[0]==1.
REQ-038 SHALL pass this case: reg_ctrl=8'h22 (loop, V=2), reg_len_update, then qtrframes -> decay=15, then decrements every 3 qtrframes down to 0, then wraps to 15.
REQ-039 SHALL pass this case: active channel, en dropped to 0 -> length=0 next clk and active=0; reg_len_update with en=0 leaves length at 0.
REQ-040 SHALL pass this case: reg_len_update coincident with halfframe -> length equals the table value, not decremented.

Source files
------------

// File: rtl/apu_noise.sv
// NES APU noise channel: period-indexed timer clocking a 15-bit LFSR,
// length counter, envelope generator and registered 4-bit sample output.
module apu_noise #(
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       apu_cycle,
    input  logic       qtrframe,
    input  logic       halfframe,
    input  logic       en,
    input  logic [7:0] reg_ctrl,
    input  logic [7:0] reg_timelow,
    input  logic [7:0] reg_timehigh,
    input  logic       reg_len_update,
    output logic       active,
    output logic [3:0] sample
);

    logic [14:0] lfsr_q, lfsr_d;
    logic [10:0] timer_q, timer_d;
    logic [7:0]  len_q, len_d;
    logic [3:0]  div_q, div_d;
    logic [3:0]  decay_q, decay_d;
    logic        start_q, start_d;
    logic [3:0]  sample_q, sample_d;

    logic [10:0] period_m1;
    logic [7:0]  len_load;
    logic        halt;
    logic        const_vol;
    logic [3:0]  vol_v;
    logic        start_set;
    logic        fb;
    logic [3:0]  volume;

    assign halt      = reg_ctrl[5];
    assign const_vol = reg_ctrl[4];
    assign vol_v     = reg_ctrl[3:0];

    // Timer reload value is the table period minus one
    always_comb begin
        period_m1 = 11'd1;
        case (reg_timelow[3:0])
            4'd0:  period_m1 = 11'd1;
            4'd1:  period_m1 = 11'd3;
            4'd2:  period_m1 = 11'd7;
            4'd3:  period_m1 = 11'd15;
            4'd4:  period_m1 = 11'd31;
            4'd5:  period_m1 = 11'd47;
            4'd6:  period_m1 = 11'd63;
            4'd7:  period_m1 = 11'd79;
            4'd8:  period_m1 = 11'd100;
            4'd9:  period_m1 = 11'd126;
            4'd10: period_m1 = 11'd189;
            4'd11: period_m1 = 11'd253;
            4'd12: period_m1 = 11'd380;
            4'd13: period_m1 = 11'd507;
            4'd14: period_m1 = 11'd1016;
            4'd15: period_m1 = 11'd2033;
            default: period_m1 = 11'd1;
        endcase
    end

    always_comb begin
        len_load = 8'd10;
        case (reg_timehigh[7:3])
            5'd0:  len_load = 8'd10;
            5'd1:  len_load = 8'd254;
            5'd2:  len_load = 8'd20;
            5'd3:  len_load = 8'd2;
            5'd4:  len_load = 8'd40;
            5'd5:  len_load = 8'd4;
            5'd6:  len_load = 8'd80;
            5'd7:  len_load = 8'd6;
            5'd8:  len_load = 8'd160;
            5'd9:  len_load = 8'd8;
            5'd10: len_load = 8'd60;
            5'd11: len_load = 8'd10;
            5'd12: len_load = 8'd14;
            5'd13: len_load = 8'd12;
            5'd14: len_load = 8'd26;
            5'd15: len_load = 8'd14;
            5'd16: len_load = 8'd12;
            5'd17: len_load = 8'd16;
            5'd18: len_load = 8'd24;
            5'd19: len_load = 8'd18;
            5'd20: len_load = 8'd48;
            5'd21: len_load = 8'd20;
            5'd22: len_load = 8'd96;
            5'd23: len_load = 8'd22;
            5'd24: len_load = 8'd192;
            5'd25: len_load = 8'd24;
            5'd26: len_load = 8'd72;
            5'd27: len_load = 8'd26;
            5'd28: len_load = 8'd16;
            5'd29: len_load = 8'd28;
            5'd30: len_load = 8'd32;
            5'd31: len_load = 8'd30;
            default: len_load = 8'd10;
        endcase
    end

    always_comb begin
        lfsr_d   = lfsr_q;
        timer_d  = timer_q;
        len_d    = len_q;
        div_d    = div_q;
        decay_d  = decay_q;
        start_d  = start_q;
        fb       = lfsr_q[0] ^ (reg_timelow[7] ? lfsr_q[6] : lfsr_q[1]);
        volume   = const_vol ? vol_v : decay_q;
        sample_d = ((len_q == 8'd0) || lfsr_q[0]) ? 4'd0 : volume;

        if (apu_cycle) begin
            if (timer_q == 11'd0) begin
                timer_d = period_m1;
                lfsr_d  = {fb, lfsr_q[14:1]};
            end else begin
                timer_d = timer_q - 11'd1;
            end
        end

        if (!en) begin
            len_d = 8'd0;
        end else if (reg_len_update) begin
            len_d = len_load;
        end else if (halfframe && !halt && (len_q != 8'd0)) begin
            len_d = len_q - 8'd1;
        end

        // A $400F write landing on a quarter-frame restarts the envelope on that same edge
        start_set = start_q | reg_len_update;
        start_d   = start_set;
        if (qtrframe) begin
            if (start_set) begin
                start_d = 1'b0;
                decay_d = 4'd15;
                div_d   = vol_v;
            end else if (div_q == 4'd0) begin
                div_d = vol_v;
                if (decay_q != 4'd0) begin
                    decay_d = decay_q - 4'd1;
                end else if (halt) begin
                    decay_d = 4'd15;
                end
            end else begin
                div_d = div_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q   <= LFSR_SEED;
            timer_q  <= '0;
            len_q    <= '0;
            div_q    <= '0;
            decay_q  <= '0;
            start_q  <= 1'b0;
            sample_q <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            timer_q  <= timer_d;
            len_q    <= len_d;
            div_q    <= div_d;
            decay_q  <= decay_d;
            start_q  <= start_d;
            sample_q <= sample_d;
        end
    end

    assign active = (len_q != 8'd0);
    assign sample = sample_q;

endmodule

// File: tb/tb_apu_noise.sv
// Scoreboarded bench for apu_noise: a table-driven reference model predicts
// each clock's outputs; a negedge monitor pops and compares.
module tb_apu_noise;

    logic       clk = 1'b0;
    logic       rst;
    logic       apu_cycle;
    logic       qtrframe;
    logic       halfframe;
    logic       en;
    logic [7:0] reg_ctrl;
    logic [7:0] reg_timelow;
    logic [7:0] reg_timehigh;
    logic       reg_len_update;
    logic       active;
    logic [3:0] sample;

    always #5 clk = ~clk;

    apu_noise #(.LFSR_SEED(15'h0001)) dut (
        .clk            (clk),
        .rst            (rst),
        .apu_cycle      (apu_cycle),
        .qtrframe       (qtrframe),
        .halfframe      (halfframe),
        .en             (en),
        .reg_ctrl       (reg_ctrl),
        .reg_timelow    (reg_timelow),
        .reg_timehigh   (reg_timehigh),
        .reg_len_update (reg_len_update),
        .active         (active),
        .sample         (sample)
    );

    typedef struct {
        int act;
        int smp;
        int lfsr;
        int dec;
        int len;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    int period_t[16] = '{2, 4, 8, 16, 32, 48, 64, 80, 101, 127, 190, 254, 381, 508, 1017, 2034};
    int len_t[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                      12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    // Reference state: m_wait counts strobes left before the next LFSR step
    int m_lfsr, m_wait, m_len, m_div, m_dec, m_smp;
    bit m_start;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model over the coming edge, queue its prediction, then take the edge
    task automatic tick();
        exp_t e;
        int   v, vol, nsmp, tap, fb;
        bit   halt;
        if (!rst) begin
            m_lfsr = 1; m_wait = 0; m_len = 0; m_div = 0; m_dec = 0; m_start = 0; m_smp = 0;
        end else begin
            v    = int'(reg_ctrl[3:0]);
            halt = reg_ctrl[5];
            vol  = reg_ctrl[4] ? v : m_dec;
            nsmp = (m_len == 0 || (m_lfsr % 2) == 1) ? 0 : vol;
            if (apu_cycle) begin
                if (m_wait == 0) begin
                    tap    = reg_timelow[7] ? 6 : 1;
                    fb     = (m_lfsr ^ (m_lfsr >> tap)) & 1;
                    m_lfsr = (m_lfsr >> 1) | (fb << 14);
                    m_wait = period_t[reg_timelow[3:0]] - 1;
                end else begin
                    m_wait--;
                end
            end
            if (!en) m_len = 0;
            else if (reg_len_update) m_len = len_t[reg_timehigh[7:3]];
            else if (halfframe && !halt && m_len > 0) m_len--;
            if (reg_len_update) m_start = 1;
            if (qtrframe) begin
                if (m_start) begin
                    m_start = 0; m_dec = 15; m_div = v;
                end else if (m_div == 0) begin
                    m_div = v;
                    if (m_dec > 0) m_dec--;
                    else if (halt) m_dec = 15;
                end else begin
                    m_div--;
                end
            end
            m_smp = nsmp;
        end
        e.act = (m_len != 0) ? 1 : 0;
        e.smp = m_smp;
        e.lfsr = m_lfsr;
        e.dec = m_dec;
        e.len = m_len;
        sb.push_back(e);
        @(posedge clk);
        #1;
        apu_cycle = 0; qtrframe = 0; halfframe = 0; reg_len_update = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("active", int'(active), e.act);
            chk("sample", int'(sample), e.smp);
            chk("lfsr", int'(dut.lfsr_q), e.lfsr);
            chk("decay", int'(dut.decay_q), e.dec);
            chk("length", int'(dut.len_q), e.len);
        end
    end

    initial begin
        rst = 0; en = 0; apu_cycle = 0; qtrframe = 0; halfframe = 0; reg_len_update = 0;
        reg_ctrl = 8'h00; reg_timelow = 8'h00; reg_timehigh = 8'h00;

        // Reset must dominate coincident strobes
        apu_cycle = 1; qtrframe = 1; halfframe = 1; reg_len_update = 1; en = 1;
        tick();
        repeat (2) tick();
        chk("reset_active", int'(active), 0);
        chk("reset_lfsr", int'(dut.lfsr_q), 1);

        // Period index 0, mode 0: step on first strobe then every second
        rst = 1; en = 1; reg_timelow = 8'h00; reg_ctrl = 8'h1A;
        for (int i = 0; i < 20; i++) begin
            apu_cycle = 1;
            tick();
            if (i == 0) chk("lfsr_step1", int'(dut.lfsr_q), 'h4000);
            if (i == 2) chk("lfsr_step2", int'(dut.lfsr_q), 'h2000);
            tick();
        end

        // Length index 1 -> 254, then drained by halfframes
        reg_timehigh = 8'h08; reg_len_update = 1;
        tick();
        chk("len_load_254", int'(dut.len_q), 254);
        chk("len_active", int'(active), 1);
        for (int i = 0; i < 254; i++) begin
            halfframe = 1; apu_cycle = 1;
            tick();
            apu_cycle = 1;
            tick();
        end
        chk("len_drained_active", int'(active), 0);
        tick();
        chk("len_drained_sample", int'(sample), 0);

        // Looping envelope, V=2, length held by halt
        reg_ctrl = 8'h22; reg_timehigh = 8'h08; reg_len_update = 1;
        tick();
        qtrframe = 1;
        tick();
        chk("env_start_decay", int'(dut.decay_q), 15);
        for (int i = 0; i < 60; i++) begin
            qtrframe = 1; apu_cycle = 1;
            tick();
            apu_cycle = 1;
            tick();
        end

        // Enable drop clears length; load ignored while disabled
        en = 0;
        tick();
        chk("en_drop_active", int'(active), 0);
        reg_len_update = 1;
        tick();
        chk("en_off_load", int'(dut.len_q), 0);
        en = 1;

        // Load coincident with halfframe: no decrement
        reg_ctrl = 8'h0A; reg_timehigh = 8'h20; reg_len_update = 1; halfframe = 1;
        tick();
        chk("len_load_prio", int'(dut.len_q), 40);

        // Mode 1 short sequence: 93 steps return to seed
        rst = 0;
        tick();
        rst = 1; reg_timelow = 8'h80;
        for (int i = 0; i < 185; i++) begin
            apu_cycle = 1;
            tick();
        end
        chk("mode1_period93", int'(dut.lfsr_q), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            en = ($urandom_range(0, 19) != 0);
            apu_cycle = ($urandom_range(0, 1) == 1);
            qtrframe = ($urandom_range(0, 7) == 0);
            halfframe = ($urandom_range(0, 7) == 0);
            reg_len_update = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) reg_ctrl = 8'($urandom);
            if ($urandom_range(0, 49) == 0)
                reg_timelow = {1'($urandom), 3'b000, 4'($urandom_range(0, 5))};
            if ($urandom_range(0, 29) == 0) reg_timehigh = 8'($urandom);
            tick();
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
